// File: rtl/wide_add_sequencer_if.sv
// Request/response channel of wide_add_sequencer; req_sub exists only with WADD_SUB_EN.
// master = issuing/consuming side, slave = sequencer side.
interface wide_add_sequencer_if #(
  parameter int W = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
`ifdef WADD_SUB_EN
  logic         req_sub;
`endif
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin,
`ifdef WADD_SUB_EN
    output req_sub,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
`ifdef WADD_SUB_EN
    input  req_sub,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide add (or subtract with WADD_SUB_EN) over a LENGTH-bit fulladder, one slice per cycle, LSB first.
// Latency CHUNKS cycles from accept to rsp_valid; rsp_ready low holds DONE, req_ready low outside IDLE.
module wide_add_sequencer #(
  parameter int LENGTH = 4,
  parameter int CHUNKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus
);
  localparam int W    = LENGTH * CHUNKS;
  localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      op_a, op_b, work_sum, sum_full;
  logic [W-1:0]      b_eff, rsp_sum_q;
  logic              cin_eff, carry, rsp_cout_q, rsp_ovf_q;
  logic [IDXW-1:0]   idx;
  logic              last;
  logic              req_ready_c, rsp_valid_c;
  logic [LENGTH-1:0] fa_a, fa_b, fa_sum;
  logic              fa_cout;

`ifdef WADD_SUB_EN
  assign b_eff   = bus.req_sub ? ~bus.req_b : bus.req_b;
  assign cin_eff = bus.req_sub ? 1'b1 : bus.req_cin;
`else
  assign b_eff   = bus.req_b;
  assign cin_eff = bus.req_cin;
`endif

  assign last = (idx == IDXW'(CHUNKS - 1));
  assign fa_a = op_a[idx*LENGTH +: LENGTH];
  assign fa_b = op_b[idx*LENGTH +: LENGTH];

  fulladder #(.LENGTH(LENGTH)) u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Working sum with the current slice merged in, so the last cycle can publish it directly.
  always_comb begin
    sum_full = work_sum;
    sum_full[idx*LENGTH +: LENGTH] = fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      work_sum   <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req_valid) begin
        op_a  <= bus.req_a;
        op_b  <= b_eff;
        carry <= cin_eff;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      work_sum <= sum_full;
      carry    <= fa_cout;
      idx      <= last ? '0 : idx + IDXW'(1);
      if (last) begin
        rsp_sum_q  <= sum_full;
        rsp_cout_q <= fa_cout;
        rsp_ovf_q  <= (op_a[W-1] == op_b[W-1]) && (sum_full[W-1] != op_a[W-1]);
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

module fulladder #(
  parameter int LENGTH = 4
) (
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  input  logic              cin,
  output logic [LENGTH-1:0] sum,
  output logic              cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LENGTH{1'b0}}, cin};
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer at LENGTH=4, CHUNKS=4; subtract cases need WADD_SUB_EN.
module tb_wide_add_sequencer;
  localparam int LENGTH = 4;
  localparam int CHUNKS = 4;
  localparam int W      = LENGTH * CHUNKS;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wide_add_sequencer_if #(.W(W)) bus ();

  wide_add_sequencer #(.LENGTH(LENGTH), .CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
`ifdef WADD_SUB_EN
    bus.req_sub   = sub;
`else
    if (sub) $display("subtract requested without WADD_SUB_EN");
`endif
  endtask

  // Issues one request, checks exact latency and result, then takes the response.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_ready_timeout: got %b expected 1", name, bus.req_ready);
    end
    drive_req(a, b, cin, sub);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({name, "_accepted"}, W'(bus.req_ready), W'(0));
    for (int k = 1; k <= CHUNKS; k++) begin
      chk({name, "_valid_early"}, W'(bus.rsp_valid), W'(0));
      @(posedge clk); #1;
    end
    chk({name, "_valid_at_latency"}, W'(bus.rsp_valid), W'(1));
    chk({name, "_sum"},  bus.rsp_sum, exp_sum);
    chk({name, "_cout"}, W'(bus.rsp_cout), W'(exp_cout));
    chk({name, "_ovf"},  W'(bus.rsp_ovf), W'(exp_ovf));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({name, "_back_idle"}, W'({bus.rsp_valid, bus.req_ready}), W'(2'b01));
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
`ifdef WADD_SUB_EN
    bus.req_sub   = 1'b0;
`endif
    bus.rsp_ready = 1'b0;
    drive_req(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", W'(bus.req_ready), W'(1));
    chk("reset_rsp_valid", W'(bus.rsp_valid), W'(0));
    chk("reset_rsp_sum",   bus.rsp_sum, 16'h0000);
    chk("reset_flags",     W'({bus.rsp_cout, bus.rsp_ovf}), W'(0));
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_no_capture", W'(bus.req_ready), W'(1));
  endtask

  task automatic test_add();
    run_op("add_ff_1",      16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_op("bp_first", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    // Put a fresh result into DONE and stall it.
    drive_req(16'h0010, 16'h0020, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (CHUNKS) @(posedge clk);
    #1;
    chk("bp_done_sum", bus.rsp_sum, 16'h0030);
    drive_req(16'h1000, 16'h0234, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_stall_valid", W'(bus.rsp_valid), W'(1));
      chk("bp_stall_sum",   bus.rsp_sum, 16'h0030);
      chk("bp_stall_ready", W'(bus.req_ready), W'(0));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_after_hs", W'({bus.rsp_valid, bus.req_ready}), W'(2'b01));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_next_accepted", W'(bus.req_ready), W'(0));
    chk("bp_sum_held_in_run", bus.rsp_sum, 16'h0030);
    repeat (CHUNKS - 1) @(posedge clk);
    #1;
    chk("bp_next_not_yet", W'(bus.rsp_valid), W'(0));
    @(posedge clk); #1;
    chk("bp_next_valid", W'(bus.rsp_valid), W'(1));
    chk("bp_next_sum",   bus.rsp_sum, 16'h1234);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    drive_req(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_pre_sum", bus.rsp_sum, 16'h1234);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", W'(bus.rsp_valid), W'(0));
    chk("rst_mid_ready", W'(bus.req_ready), W'(1));
    chk("rst_mid_sum",   bus.rsp_sum, 16'h0000);
    chk("rst_mid_flags", W'({bus.rsp_cout, bus.rsp_ovf}), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("rst_rerun", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
  endtask

`ifdef WADD_SUB_EN
  task automatic test_subtract();
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_off",    16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_mid_run_reset();
`ifdef WADD_SUB_EN
    test_subtract();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
